// File: rtl/divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder
// over N cycles, with the same start/ready handshake as the shift-add multiplier.
module divider #(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  output logic           ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           error
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N:0]    r_rem;
  logic [N:0]    w_rem_nxt;
  logic [N-1:0]  r_q;
  logic [N-1:0]  w_q_nxt;
  logic [N-1:0]  r_d;
  logic [N-1:0]  w_d_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_ready;
  logic          w_ready_nxt;
  logic [N-1:0]  r_quotient;
  logic [N-1:0]  w_quotient_nxt;
  logic [N-1:0]  r_remainder;
  logic [N-1:0]  w_remainder_nxt;
  logic          r_error;
  logic          w_error_nxt;

  logic [N-1:0]  w_hi;
  logic          w_fault;
  logic [N+1:0]  w_wide;
  logic [N+1:0]  w_trial;
  logic          w_fits;
  logic [N:0]    w_rem_step;
  logic [N-1:0]  w_q_step;

  // A quotient that fits in N bits requires the upper dividend half to be below the divisor.
  assign w_hi    = dividend[2*N-1:N];
  assign w_fault = (divisor == {N{1'b0}}) || (w_hi >= divisor);

  // {R,Q} shifted left once; the trial subtraction carries one extra bit so its MSB is the borrow.
  assign w_wide     = {r_rem, r_q[N-1]};
  assign w_trial    = w_wide - {2'b00, r_d};
  assign w_fits     = ~w_trial[N+1];
  assign w_rem_step = w_fits ? w_trial[N:0] : w_wide[N:0];
  assign w_q_step   = {r_q[N-2:0], w_fits};

  assign ready     = r_ready;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign error     = r_error;

  // Next-state, datapath and result update for the IDLE/BUSY/FAULT controller.
  always_comb begin
    w_state_nxt     = r_state;
    w_rem_nxt       = r_rem;
    w_q_nxt         = r_q;
    w_d_nxt         = r_d;
    w_cnt_nxt       = r_cnt;
    w_ready_nxt     = r_ready;
    w_quotient_nxt  = r_quotient;
    w_remainder_nxt = r_remainder;
    w_error_nxt     = r_error;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_ready_nxt = 1'b0;
          if (w_fault) begin
            w_state_nxt = S_FAULT;
            w_error_nxt = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
            w_error_nxt = 1'b0;
            w_rem_nxt   = {1'b0, w_hi};
            w_q_nxt     = dividend[N-1:0];
            w_d_nxt     = divisor;
            w_cnt_nxt   = CW'(N);
          end
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        w_rem_nxt = w_rem_step;
        w_q_nxt   = w_q_step;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt     = S_IDLE;
          w_ready_nxt     = 1'b1;
          w_quotient_nxt  = w_q_step;
          w_remainder_nxt = w_rem_step[N-1:0];
        end else begin
          w_ready_nxt = 1'b0;
        end
      end
      S_FAULT: begin
        w_state_nxt     = S_IDLE;
        w_ready_nxt     = 1'b1;
        w_quotient_nxt  = {N{1'b1}};
        w_remainder_nxt = {N{1'b0}};
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= {(N+1){1'b0}};
      r_q         <= {N{1'b0}};
      r_d         <= {N{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_ready     <= 1'b1;
      r_quotient  <= {N{1'b0}};
      r_remainder <= {N{1'b0}};
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_q         <= w_q_nxt;
      r_d         <= w_d_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ready     <= w_ready_nxt;
      r_quotient  <= w_quotient_nxt;
      r_remainder <= w_remainder_nxt;
      r_error     <= w_error_nxt;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed N=4 cases plus randomized N=8 operands against an
// arithmetic reference model.
module tb_divider;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        err;
    int          lat;
    logic [15:0] dvd;
    logic [7:0]  dvs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start4, rdy4, err4;
  logic [7:0]  dvd4;
  logic [3:0]  dvs4, q4, r4;
  logic        start8, rdy8, err8;
  logic [15:0] dvd8;
  logic [7:0]  dvs8, q8, r8;

  int n_vec = 0;
  int n_bad = 0;
  exp_t sb4[$];
  exp_t sb8[$];

  divider #(.N(4)) u_div4 (
    .clock(clk), .reset(rst), .start(start4), .ready(rdy4),
    .dividend(dvd4), .divisor(dvs4), .quotient(q4), .remainder(r4), .error(err4)
  );

  divider #(.N(8)) u_div8 (
    .clock(clk), .reset(rst), .start(start8), .ready(rdy8),
    .dividend(dvd8), .divisor(dvs8), .quotient(q8), .remainder(r8), .error(err8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer division; a fault is a zero divisor or a quotient needing > n bits.
  function automatic exp_t model(input int n, input logic [15:0] dvd, input logic [7:0] dvs);
    exp_t e;
    int unsigned a, b, lim;
    a = int'(dvd);
    b = int'(dvs);
    lim = 32'd1 << n;
    e.dvd = dvd;
    e.dvs = dvs;
    if (b == 0 || (a / b) >= lim) begin
      e.err = 1'b1; e.q = 8'(lim - 1); e.r = 8'h00; e.lat = 1;
    end else begin
      e.err = 1'b0; e.q = 8'(a / b); e.r = 8'(a % b); e.lat = n;
    end
    return e;
  endfunction

  task automatic wait_idle4();
    int k = 0;
    @(negedge clk);
    while (!rdy4 && k < 100) begin @(negedge clk); k++; end
    if (!rdy4) chk("wait_idle4_timeout", rdy4, 1);
  endtask

  task automatic wait_idle8();
    int k = 0;
    @(negedge clk);
    while (!rdy8 && k < 100) begin @(negedge clk); k++; end
    if (!rdy8) chk("wait_idle8_timeout", rdy8, 1);
  endtask

  task automatic issue4(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    e = model(4, {8'h00, a}, {4'h0, b});
    start4 = 1'b1; dvd4 = a; dvs4 = b;
    sb4.push_back(e);
    @(posedge clk); #1;
    start4 = 1'b0; dvd4 = 8'($urandom); dvs4 = 4'($urandom);
    chk("accept_ready4", rdy4, 0);
    chk("accept_err4", err4, e.err);
  endtask

  task automatic issue8(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    e = model(8, a, b);
    start8 = 1'b1; dvd8 = a; dvs8 = b;
    sb8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0; dvd8 = 16'($urandom); dvs8 = 8'($urandom);
    chk("accept_err8", err8, e.err);
  endtask

  // Monitor for N=4: each rising ready completes the oldest outstanding request.
  initial begin
    bit prev = 1'b1;
    int low = 0;
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        prev = 1'b1; low = 0;
      end else begin
        if (!rdy4) low++;
        else if (!prev) begin
          if (sb4.size() == 0) chk("sb4_unexpected_result", 1, 0);
          else begin
            e = sb4.pop_front();
            chk("quotient4", {4'h0, q4}, e.q);
            chk("remainder4", {4'h0, r4}, e.r);
            chk("error4", err4, e.err);
            chk("latency4", low, e.lat);
          end
          low = 0;
        end
        prev = rdy4;
      end
    end
  end

  // Monitor for N=8, which also checks the multiply-back identity on good results.
  initial begin
    bit prev = 1'b1;
    int low = 0;
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        prev = 1'b1; low = 0;
      end else begin
        if (!rdy8) low++;
        else if (!prev) begin
          if (sb8.size() == 0) chk("sb8_unexpected_result", 1, 0);
          else begin
            e = sb8.pop_front();
            chk("quotient8", q8, e.q);
            chk("remainder8", r8, e.r);
            chk("error8", err8, e.err);
            chk("latency8", low, e.lat);
            if (!e.err) begin
              chk("mulback8", 32'(q8) * 32'(e.dvs), 32'(e.dvd) - 32'(r8));
              chk("rem_lt_div8", 32'(r8 < e.dvs), 1);
            end
          end
          low = 0;
        end
        prev = rdy8;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dv, hi, lo;
    start4 = 1'b0; dvd4 = 8'h00; dvs4 = 4'h0;
    start8 = 1'b0; dvd8 = 16'h0000; dvs8 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready4", rdy4, 1);
    chk("reset_quot4", q4, 0);
    chk("reset_rem4", r4, 0);
    chk("reset_err4", err4, 0);
    chk("reset_ready8", rdy8, 1);
    chk("reset_quot8", q8, 0);
    rst = 1'b0;

    wait_idle4(); issue4(8'h4B, 4'd7);
    wait_idle4(); issue4(8'hE1, 4'hF);
    wait_idle4(); issue4(8'h00, 4'd3);
    wait_idle4(); issue4(8'h12, 4'd0);
    wait_idle4(); issue4(8'h50, 4'd5);

    // start with new operands mid-operation must be ignored
    wait_idle4(); issue4(8'h4B, 4'd7);
    @(negedge clk); @(negedge clk);
    start4 = 1'b1; dvd4 = 8'h21; dvs4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0;

    // start held high: two operations back to back with one ready cycle between
    wait_idle4();
    sb4.push_back(model(4, 16'h0037, 8'h06));
    sb4.push_back(model(4, 16'h00C8, 8'h0D));
    start4 = 1'b1; dvd4 = 8'h37; dvs4 = 4'd6;
    @(posedge clk); #1;
    dvd4 = 8'hC8; dvs4 = 4'hD;
    wait_idle4();
    @(posedge clk); #1;
    chk("b2b_ready_one_cycle", rdy4, 0);
    start4 = 1'b0;

    // reset in the second BUSY cycle aborts with no partial result
    wait_idle4(); issue4(8'h50, 4'd5);
    wait_idle4(); issue4(8'h4B, 4'd7);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready4", rdy4, 1);
    chk("midrst_quot4", q4, 0);
    chk("midrst_rem4", r4, 0);
    chk("midrst_err4", err4, 0);
    sb4.delete();
    #1;
    rst = 1'b0;
    wait_idle4(); issue4(8'h4B, 4'd7);
    wait_idle4();

    for (int i = 0; i < 1000; i++) begin
      dv = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(dv) - 1));
      lo = 8'($urandom);
      if (i % 40 == 7) dv = 8'h00;
      else if (i % 40 == 23) hi = 8'($urandom_range(int'(dv), 255));
      wait_idle8();
      issue8({hi, lo}, dv);
    end
    wait_idle8();
    wait_idle4();
    @(negedge clk);
    chk("sb4_drained", sb4.size(), 0);
    chk("sb8_drained", sb8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
